// File: rtl/torus_link_ep_pkg.sv
// ============================================================================
// Module      : torus_link_ep_pkg
// Description : Shared torus link definitions: default flit geometry, port
//               bit positions and direction indices used by the connector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package torus_link_ep_pkg;

    localparam int DATA_SIZE = 37;
    localparam int PORT_SIZE = DATA_SIZE + 2;
    localparam int VALID_BIT = DATA_SIZE;
    localparam int ACK_BIT   = DATA_SIZE + 1;

    typedef enum logic [1:0] {
        DIR_NORTH = 2'd0,
        DIR_EAST  = 2'd1,
        DIR_SOUTH = 2'd2,
        DIR_WEST  = 2'd3
    } dir_e;

    // Bit positions follow the payload width, so parameterised endpoints
    // derive them from their own DATA_SIZE rather than the defaults above.
    function automatic int valid_bit(input int data_size);
        return data_size;
    endfunction

    function automatic int ack_bit(input int data_size);
        return data_size + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/torus_link_ep_link_fifo.sv
// ============================================================================
// Module      : link_fifo
// Description : Power-of-two receive FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module link_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr_q, w_wr_ptr_d;
    logic [c_aw-1:0]  r_rd_ptr_q, w_rd_ptr_d;
    logic [c_cw-1:0]  r_count_q,  w_count_d;
    logic             w_wr;
    logic             w_rd;

    assign full_o  = (r_count_q == c_cw'(DEPTH));
    assign empty_o = (r_count_q == '0);
    assign count_o = r_count_q;
    assign dout_o  = r_mem_q[r_rd_ptr_q];
    assign w_wr    = push_i & ~full_o;
    assign w_rd    = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q + (w_wr ? c_aw'(1) : '0);
        w_rd_ptr_d = r_rd_ptr_q + (w_rd ? c_aw'(1) : '0);
        w_count_d  = r_count_q + c_cw'(w_wr) - c_cw'(w_rd);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem_q[r_wr_ptr_q] <= din_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/torus_link_ep.sv
// ============================================================================
// Module      : torus_link_ep
// Description : Torus link endpoint: TX holding register plus credit-free
//               ack-gated RX FIFO on one connector port slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module torus_link_ep #(
    parameter int DATA_SIZE  = torus_link_ep_pkg::DATA_SIZE,
    parameter int PORT_SIZE  = DATA_SIZE + 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [PORT_SIZE-1:0]          port_i,
    output logic [PORT_SIZE-1:0]          port_o,
    input  logic [DATA_SIZE-1:0]          tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic [DATA_SIZE-1:0]          rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count_o
);

    import torus_link_ep_pkg::*;

    localparam int c_vld_bit = valid_bit(DATA_SIZE);
    localparam int c_ack_bit = ack_bit(DATA_SIZE);
    localparam int c_cnt_w   = $clog2(FIFO_DEPTH) + 1;

    logic                 r_hold_valid_q, w_hold_valid_d;
    logic [DATA_SIZE-1:0] r_hold_data_q,  w_hold_data_d;
    logic                 r_ack_q,        w_ack_d;

    logic                 w_link_ack;
    logic                 w_link_valid;
    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_cnt_w-1:0]   w_count;
    logic [c_cnt_w-1:0]   w_count_next;

    assign w_link_ack   = port_i[c_ack_bit];
    assign w_link_valid = port_i[c_vld_bit];
    assign port_o       = PORT_SIZE'({r_ack_q, r_hold_valid_q, r_hold_data_q});

    assign tx_ready_o = ~r_hold_valid_q | w_link_ack;
    assign w_accept   = tx_valid_i & tx_ready_o;
    assign w_xfer     = r_hold_valid_q & w_link_ack;

    always_comb begin
        w_hold_valid_d = r_hold_valid_q;
        w_hold_data_d  = r_hold_data_q;
        if (w_accept) begin
            w_hold_valid_d = 1'b1;
            w_hold_data_d  = tx_data_i;
        end else if (w_xfer) begin
            w_hold_valid_d = 1'b0;
        end
    end

    // ack is only raised when the post-edge count leaves a free slot, so the
    // full term below never actually blocks a link write.
    assign w_push       = w_link_valid & r_ack_q & ~w_full;
    assign w_pop        = rx_valid_o & rx_ready_i;
    assign w_count_next = w_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    assign w_ack_d      = (w_count_next < c_cnt_w'(FIFO_DEPTH));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hold_valid_q <= 1'b0;
            r_hold_data_q  <= '0;
            r_ack_q        <= 1'b0;
        end else begin
            r_hold_valid_q <= w_hold_valid_d;
            r_hold_data_q  <= w_hold_data_d;
            r_ack_q        <= w_ack_d;
        end
    end

    link_fifo #(
        .WIDTH (DATA_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .din_i   (port_i[DATA_SIZE-1:0]),
        .pop_i   (w_pop),
        .dout_o  (rx_data_o),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign rx_valid_o = ~w_empty;
    assign rx_count_o = w_count;

endmodule

`default_nettype wire

// File: tb/tb_torus_link_ep.sv
// ============================================================================
// Module      : tb_torus_link_ep
// Description : Two cross-wired torus link endpoints with directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_torus_link_ep;

    localparam int DW = 37;
    localparam int PW = 39;
    localparam int VB = 37;
    localparam int AB = 38;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] a_port_o, b_port_o;
    logic [DW-1:0] a_tx_data, b_tx_data, a_rx_data, b_rx_data;
    logic          a_tx_valid, b_tx_valid, a_tx_ready, b_tx_ready;
    logic          a_rx_valid, b_rx_valid, a_rx_ready, b_rx_ready;
    logic [CW-1:0] a_rx_count, b_rx_count;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] src_a[$], src_b[$], got_ab[$], got_ba[$];
    logic          a_en, b_en;

    always #5 clk = ~clk;

    torus_link_ep u_a (
        .clk_i(clk), .rst_i(rst), .port_i(b_port_o), .port_o(a_port_o),
        .tx_data_i(a_tx_data), .tx_valid_i(a_tx_valid), .tx_ready_o(a_tx_ready),
        .rx_data_o(a_rx_data), .rx_valid_o(a_rx_valid), .rx_ready_i(a_rx_ready),
        .rx_count_o(a_rx_count)
    );

    torus_link_ep u_b (
        .clk_i(clk), .rst_i(rst), .port_i(a_port_o), .port_o(b_port_o),
        .tx_data_i(b_tx_data), .tx_valid_i(b_tx_valid), .tx_ready_o(b_tx_ready),
        .rx_data_o(b_rx_data), .rx_valid_o(b_rx_valid), .rx_ready_i(b_rx_ready),
        .rx_count_o(b_rx_count)
    );

    function automatic void drive_tx();
        a_tx_valid = a_en && (src_a.size() != 0);
        a_tx_data  = (src_a.size() != 0) ? src_a[0] : '0;
        b_tx_valid = b_en && (src_b.size() != 0);
        b_tx_data  = (src_b.size() != 0) ? src_b[0] : '0;
    endfunction

    // One clock: record handshakes seen before the edge, then re-drive sources.
    task automatic step();
        logic          acc_a, acc_b, pop_a, pop_b;
        logic [DW-1:0] da, db;
        acc_a = a_tx_valid & a_tx_ready;
        acc_b = b_tx_valid & b_tx_ready;
        pop_a = a_rx_valid & a_rx_ready;
        pop_b = b_rx_valid & b_rx_ready;
        da = a_rx_data;
        db = b_rx_data;
        @(posedge clk);
        #1;
        if (acc_a === 1'b1) void'(src_a.pop_front());
        if (acc_b === 1'b1) void'(src_b.pop_front());
        if (pop_b === 1'b1) got_ab.push_back(db);
        if (pop_a === 1'b1) got_ba.push_back(da);
        drive_tx();
    endtask

    function automatic void clear_queues();
        src_a.delete(); src_b.delete(); got_ab.delete(); got_ba.delete();
    endfunction

    task automatic test_reset();
        rst = 1'b1; a_en = 1'b0; b_en = 1'b0;
        a_rx_ready = 1'b1; b_rx_ready = 1'b1;
        drive_tx();
        repeat (2) step();
        tests_run++;
        if (a_port_o !== '0 || b_port_o !== '0) begin
            tests_failed++; $display("FAIL reset_port_o: a=%h b=%h want 0", a_port_o, b_port_o);
        end
        tests_run++;
        if (b_rx_valid !== 1'b0 || b_rx_count !== 3'd0) begin
            tests_failed++; $display("FAIL reset_rx: valid=%b count=%0d want 0/0", b_rx_valid, b_rx_count);
        end
        rst = 1'b0;
        step();
        tests_run++;
        if (a_port_o[AB] !== 1'b1 || b_port_o[AB] !== 1'b1) begin
            tests_failed++; $display("FAIL first_ack: a=%b b=%b want 1", a_port_o[AB], b_port_o[AB]);
        end
        tests_run++;
        if (a_tx_ready !== 1'b1) begin
            tests_failed++; $display("FAIL post_reset_tx_ready: got %b want 1", a_tx_ready);
        end
        clear_queues();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_d [3];
        clear_queues();
        exp_d[0] = 37'h1; exp_d[1] = 37'h2; exp_d[2] = 37'h3;
        src_a.push_back(37'h1); src_a.push_back(37'h2); src_a.push_back(37'h3);
        a_en = 1'b1; b_rx_ready = 1'b1;
        drive_tx();
        step();
        tests_run++;
        if (a_tx_ready !== 1'b1 || b_rx_valid !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_cycle1: tx_ready=%b rx_valid=%b want 1/0", a_tx_ready, b_rx_valid);
        end
        // Accept was before edge 0; data appears after edge 1, then one per cycle.
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (b_rx_valid !== 1'b1 || b_rx_data !== exp_d[i]) begin
                tests_failed++;
                $display("FAIL b2b_data%0d: valid=%b data=%h want 1/%h", i, b_rx_valid, b_rx_data, exp_d[i]);
            end
        end
        step();
        tests_run++;
        if (b_rx_valid !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_drained: rx_valid=%b want 0", b_rx_valid);
        end
    endtask

    task automatic test_full();
        int bad = 0;
        clear_queues();
        for (int i = 0; i < 6; i++) src_a.push_back(DW'(8'h11 + i));
        a_en = 1'b1; b_rx_ready = 1'b0;
        drive_tx();
        repeat (10) step();
        tests_run++;
        if (b_rx_count !== 3'd4 || b_port_o[AB] !== 1'b0) begin
            tests_failed++; $display("FAIL full_count_ack: count=%0d ack=%b want 4/0", b_rx_count, b_port_o[AB]);
        end
        tests_run++;
        if (a_tx_ready !== 1'b0 || a_port_o[VB] !== 1'b1 || a_port_o[DW-1:0] !== 37'h15) begin
            tests_failed++;
            $display("FAIL full_hold: tx_ready=%b valid=%b data=%h want 0/1/15", a_tx_ready, a_port_o[VB], a_port_o[DW-1:0]);
        end
        repeat (3) step();
        tests_run++;
        if (a_port_o[DW-1:0] !== 37'h15 || b_rx_count !== 3'd4 || src_a.size() != 1) begin
            tests_failed++;
            $display("FAIL full_stable: data=%h count=%0d pending=%0d want 15/4/1", a_port_o[DW-1:0], b_rx_count, src_a.size());
        end
        b_rx_ready = 1'b1;
        for (int c = 0; c < 30 && got_ab.size() < 6; c++) step();
        for (int i = 0; i < 6; i++) if (i >= got_ab.size() || got_ab[i] !== DW'(8'h11 + i)) bad++;
        tests_run++;
        if (bad != 0 || got_ab.size() != 6) begin
            tests_failed++; $display("FAIL full_drain_order: got %0d flits, %0d wrong, want 6/0", got_ab.size(), bad);
        end
    endtask

    task automatic test_push_pop_full();
        int bad = 0;
        clear_queues();
        for (int i = 0; i < 6; i++) src_a.push_back(DW'(8'h41 + i));
        a_en = 1'b1; b_rx_ready = 1'b0;
        drive_tx();
        repeat (10) step();
        b_rx_ready = 1'b1;
        step();
        b_rx_ready = 1'b0;
        tests_run++;
        if (b_port_o[AB] !== 1'b1 || b_rx_count !== 3'd3) begin
            tests_failed++; $display("FAIL pop_at_full: ack=%b count=%0d want 1/3", b_port_o[AB], b_rx_count);
        end
        step();
        tests_run++;
        if (b_port_o[AB] !== 1'b0 || b_rx_count !== 3'd4) begin
            tests_failed++; $display("FAIL refill: ack=%b count=%0d want 0/4", b_port_o[AB], b_rx_count);
        end
        step();
        tests_run++;
        if (b_rx_count !== 3'd4) begin
            tests_failed++; $display("FAIL no_overflow: count=%0d want 4", b_rx_count);
        end
        b_rx_ready = 1'b1;
        for (int c = 0; c < 30 && got_ab.size() < 6; c++) step();
        for (int i = 0; i < 6; i++) if (i >= got_ab.size() || got_ab[i] !== DW'(8'h41 + i)) bad++;
        tests_run++;
        if (bad != 0 || got_ab.size() != 6) begin
            tests_failed++; $display("FAIL ppfull_order: got %0d flits, %0d wrong, want 6/0", got_ab.size(), bad);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        clear_queues();
        src_a.push_back(37'h21); src_a.push_back(37'h22);
        a_en = 1'b1; b_rx_ready = 1'b0;
        drive_tx();
        repeat (5) step();
        tests_run++;
        if (b_rx_count !== 3'd2) begin
            tests_failed++; $display("FAIL mid_buffered: count=%0d want 2", b_rx_count);
        end
        rst = 1'b1;
        step();
        tests_run++;
        if (b_rx_valid !== 1'b0 || b_rx_count !== 3'd0 || a_port_o !== '0 || b_port_o !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset: valid=%b count=%0d a_port=%h b_port=%h want 0", b_rx_valid, b_rx_count, a_port_o, b_port_o);
        end
        rst = 1'b0;
        step();
        clear_queues();
        src_a.push_back(37'h31); src_a.push_back(37'h32); src_a.push_back(37'h33);
        b_rx_ready = 1'b1;
        drive_tx();
        for (int c = 0; c < 30 && got_ab.size() < 3; c++) step();
        for (int i = 0; i < 3; i++) if (i >= got_ab.size() || got_ab[i] !== DW'(8'h31 + i)) bad++;
        tests_run++;
        if (bad != 0 || got_ab.size() != 3) begin
            tests_failed++; $display("FAIL mid_resume: got %0d flits, %0d wrong, want 3/0", got_ab.size(), bad);
        end
    endtask

    task automatic test_bidirectional();
        logic [DW-1:0] exp_ab[$], exp_ba[$];
        logic [63:0]   r;
        int            bad_ab = 0, bad_ba = 0;
        clear_queues();
        for (int i = 0; i < 100; i++) begin
            r = {$urandom(), $urandom()}; src_a.push_back(r[DW-1:0]); exp_ab.push_back(r[DW-1:0]);
            r = {$urandom(), $urandom()}; src_b.push_back(r[DW-1:0]); exp_ba.push_back(r[DW-1:0]);
        end
        for (int c = 0; c < 3000 && !(got_ab.size() == 100 && got_ba.size() == 100); c++) begin
            a_en       = (c > 1500) || ($urandom_range(0, 3) != 0);
            b_en       = (c > 1500) || ($urandom_range(0, 3) != 0);
            a_rx_ready = (c > 1500) || ($urandom_range(0, 2) != 0);
            b_rx_ready = (c > 1500) || ($urandom_range(0, 2) != 0);
            drive_tx();
            step();
        end
        for (int i = 0; i < 100; i++) begin
            if (i >= got_ab.size() || got_ab[i] !== exp_ab[i]) bad_ab++;
            if (i >= got_ba.size() || got_ba[i] !== exp_ba[i]) bad_ba++;
        end
        tests_run++;
        if (bad_ab != 0 || got_ab.size() != 100) begin
            tests_failed++; $display("FAIL bidir_a_to_b: got %0d flits, %0d wrong, want 100/0", got_ab.size(), bad_ab);
        end
        tests_run++;
        if (bad_ba != 0 || got_ba.size() != 100) begin
            tests_failed++; $display("FAIL bidir_b_to_a: got %0d flits, %0d wrong, want 100/0", got_ba.size(), bad_ba);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_full();
        test_push_pop_full();
        test_reset_mid();
        test_bidirectional();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
